// File: rtl/ompss_axis_pkg.sv
// Shared types for the OmpSs AXIS subset register slice: packet FSM states and
// beat payload width helper used by the top and its skid buffer.
package ompss_axis_pkg;

   typedef enum logic {
      PKT_IDLE = 1'b0,
      PKT_IN   = 1'b1
   } pkt_state_t;

   localparam int PKT_CNT_W = 32;

   // A beat is packed as {data, dest, last}; the struct itself lives in the top
   // because its field widths come from module parameters.
   function automatic int beat_width(input int data_w, input int dest_w);
      return data_w + dest_w + 1;
   endfunction

endpackage

// File: rtl/ompss_axis_skid_buf.sv
// Generic two-entry skid buffer over a W-bit payload; full throughput, one cycle
// latency, all outputs registered.
module ompss_axis_skid_buf
   import ompss_axis_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         areset_i,
   input  logic         s_valid_i,
   output logic         s_ready_o,
   input  logic [W-1:0] s_data_i,
   output logic         m_valid_o,
   input  logic         m_ready_i,
   output logic [W-1:0] m_data_o
);

   // Handshake: a beat moves on an edge where valid & ready are both 1. Once
   // m_valid_o is raised it and m_data_o hold until m_ready_i is seen; s_ready_o
   // is registered and drops only when the skid entry is occupied.
   logic         main_valid_q, main_valid_d;
   logic [W-1:0] main_data_q,  main_data_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] skid_data_q,  skid_data_d;
   logic         ready_q,      ready_d;
   logic         s_fire;
   logic         m_fire;

   assign s_fire = s_valid_i & ready_q;
   assign m_fire = main_valid_q & m_ready_i;

   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (!main_valid_q || m_fire) begin
         if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            skid_valid_d = s_fire;
            if (s_fire) begin
               skid_data_d = s_data_i;
            end
         end else if (s_fire) begin
            main_valid_d = 1'b1;
            main_data_d  = s_data_i;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (s_fire) begin
         skid_valid_d = 1'b1;
         skid_data_d  = s_data_i;
      end
      ready_d = ~skid_valid_d;
   end

   // ready_q resets low so the source is held off until the first edge after release.
   always_ff @(posedge clk_i or posedge areset_i) begin
      if (areset_i) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         ready_q      <= 1'b0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         ready_q      <= ready_d;
      end
   end

   assign s_ready_o = ready_q;
   assign m_valid_o = main_valid_q;
   assign m_data_o  = main_data_q;

endmodule

// File: rtl/ompss_axis_subset_regslice.sv
// AXIS subset converter with registered skid path, constant tid, packet tracking and
// tdest lock. Optional AXIS_SUBSET_PKT_CNT_EN adds a pkt_count output.
module ompss_axis_subset_regslice
   import ompss_axis_pkg::*;
#(
   parameter int                  DATA_WIDTH = 64,
   parameter int                  DEST_WIDTH = 2,
   parameter int                  ID_WIDTH   = 1,
   parameter logic [ID_WIDTH-1:0] ID         = '0,
   parameter bit                  LOCK_DEST  = 1'b1
) (
   input  logic                  clk,
   input  logic                  areset,
   input  logic                  S_AXIS_tvalid,
   output logic                  S_AXIS_tready,
   input  logic [DATA_WIDTH-1:0] S_AXIS_tdata,
   input  logic [DEST_WIDTH-1:0] S_AXIS_tdest,
   input  logic                  S_AXIS_tlast,
   output logic                  M_AXIS_tvalid,
   input  logic                  M_AXIS_tready,
   output logic [DATA_WIDTH-1:0] M_AXIS_tdata,
   output logic [DEST_WIDTH-1:0] M_AXIS_tdest,
   output logic [ID_WIDTH-1:0]   M_AXIS_tid,
   output logic                  M_AXIS_tlast,
   output logic                  pkt_active,
   output pkt_state_t            dbg_state_o,
   output logic                  dest_err
`ifdef AXIS_SUBSET_PKT_CNT_EN
   ,
   output logic [31:0]           pkt_count
`endif
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [DEST_WIDTH-1:0] dest;
      logic                  last;
   } beat_t;

   localparam int BEAT_W = beat_width(DATA_WIDTH, DEST_WIDTH);

   pkt_state_t            state_q, state_d;
   logic [DEST_WIDTH-1:0] dest_q, dest_d;
   logic                  dest_err_q, dest_err_d;
   logic                  s_ready;
   logic                  s_fire;
   logic                  m_valid;
   beat_t                 s_beat;
   beat_t                 m_beat;

   assign s_fire = S_AXIS_tvalid & s_ready;

   // The FSM follows accepted input beats, so dest_q is the first beat's tdest.
   always_comb begin
      state_d     = state_q;
      dest_d      = dest_q;
      dest_err_d  = 1'b0;
      s_beat.data = S_AXIS_tdata;
      s_beat.dest = S_AXIS_tdest;
      s_beat.last = S_AXIS_tlast;
      if (LOCK_DEST && (state_q == PKT_IN)) begin
         s_beat.dest = dest_q;
      end
      case (state_q)
         PKT_IDLE: begin
            if (s_fire && !S_AXIS_tlast) begin
               state_d = PKT_IN;
               dest_d  = S_AXIS_tdest;
            end
         end
         PKT_IN: begin
            if (s_fire) begin
               dest_err_d = (S_AXIS_tdest != dest_q);
               if (S_AXIS_tlast) begin
                  state_d = PKT_IDLE;
               end
            end
         end
         default: state_d = PKT_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q    <= PKT_IDLE;
         dest_q     <= '0;
         dest_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         dest_q     <= dest_d;
         dest_err_q <= dest_err_d;
      end
   end

   ompss_axis_skid_buf #(
      .W (BEAT_W)
   ) u_skid (
      .clk_i     (clk),
      .areset_i  (areset),
      .s_valid_i (S_AXIS_tvalid),
      .s_ready_o (s_ready),
      .s_data_i  (s_beat),
      .m_valid_o (m_valid),
      .m_ready_i (M_AXIS_tready),
      .m_data_o  (m_beat)
   );

   assign S_AXIS_tready = s_ready;
   assign M_AXIS_tvalid = m_valid;
   assign M_AXIS_tdata  = m_beat.data;
   assign M_AXIS_tdest  = m_beat.dest;
   assign M_AXIS_tlast  = m_beat.last;
   assign M_AXIS_tid    = ID;
   assign pkt_active    = (state_q == PKT_IN);
   assign dbg_state_o   = state_q;
   assign dest_err      = dest_err_q;

`ifdef AXIS_SUBSET_PKT_CNT_EN
   logic        m_fire;
   logic [31:0] pkt_cnt_q, pkt_cnt_d;

   assign m_fire = m_valid & M_AXIS_tready;

   // Counts packets as they leave, wrapping naturally at 2^32.
   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (m_fire && m_beat.last) begin
         pkt_cnt_d = pkt_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         pkt_cnt_q <= '0;
      end else begin
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   assign pkt_count = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_ompss_axis_subset_regslice.sv
// Directed bench for ompss_axis_subset_regslice: driver tasks push expected beats into
// a queue and a negedge monitor pops and compares every M_AXIS transfer.
module tb_ompss_axis_subset_regslice;
   import ompss_axis_pkg::*;

   localparam int              DW     = 64;
   localparam int              DESTW  = 2;
   localparam int              IDW    = 1;
   localparam logic [IDW-1:0]  ID_VAL = 1'b1;
   localparam int              EW     = DW + DESTW + 1;
   localparam int              TMO    = 50;

   logic              clk      = 1'b0;
   logic              areset   = 1'b1;
   logic              s_tvalid = 1'b0;
   logic              s_tready;
   logic [DW-1:0]     s_tdata  = '0;
   logic [DESTW-1:0]  s_tdest  = '0;
   logic              s_tlast  = 1'b0;
   logic              m_tvalid;
   logic              m_tready = 1'b0;
   logic [DW-1:0]     m_tdata;
   logic [DESTW-1:0]  m_tdest;
   logic [IDW-1:0]    m_tid;
   logic              m_tlast;
   logic              pkt_active;
   pkt_state_t        dbg_state;
   logic              dest_err;
`ifdef AXIS_SUBSET_PKT_CNT_EN
   logic [31:0]       pkt_count;
   logic              stall_done = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int acc_cnt  = 0;
   int out_cnt  = 0;
   int err_cnt  = 0;
   int c0, o0, a0, e0;
   int stall_n;
   logic [EW-1:0] exp_q[$];

   ompss_axis_subset_regslice #(
      .DATA_WIDTH (DW),
      .DEST_WIDTH (DESTW),
      .ID_WIDTH   (IDW),
      .ID         (ID_VAL),
      .LOCK_DEST  (1'b1)
   ) dut (
      .clk           (clk),
      .areset        (areset),
      .S_AXIS_tvalid (s_tvalid),
      .S_AXIS_tready (s_tready),
      .S_AXIS_tdata  (s_tdata),
      .S_AXIS_tdest  (s_tdest),
      .S_AXIS_tlast  (s_tlast),
      .M_AXIS_tvalid (m_tvalid),
      .M_AXIS_tready (m_tready),
      .M_AXIS_tdata  (m_tdata),
      .M_AXIS_tdest  (m_tdest),
      .M_AXIS_tid    (m_tid),
      .M_AXIS_tlast  (m_tlast),
      .pkt_active    (pkt_active),
      .dbg_state_o   (dbg_state),
      .dest_err      (dest_err)
`ifdef AXIS_SUBSET_PKT_CNT_EN
      ,
      .pkt_count     (pkt_count)
`endif
   );

   // Clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Driver: hold one beat until accepted, then queue its expected output.
   task automatic send(input logic [DW-1:0] d, input logic [DESTW-1:0] dest,
                       input logic last, input logic [DESTW-1:0] exp_dest);
      logic acc;
      acc      = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tdest  = dest;
      s_tlast  = last;
      for (int i = 0; i < TMO && !acc; i++) begin
         @(negedge clk);
         acc = s_tready;
         @(posedge clk);
         #1;
      end
      s_tvalid = 1'b0;
      if (acc) begin
         exp_q.push_back({d, exp_dest, last});
         acc_cnt++;
      end else begin
         check("send_timeout", acc, 1'b1);
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain", exp_q.size(), 0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      logic [EW-1:0] exp;
      check("tid", m_tid, ID_VAL);
      if (!areset) begin
         if (dest_err) err_cnt++;
         if (m_tvalid && m_tready) begin
            check("queue_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               exp = exp_q.pop_front();
               check("beat", {m_tdata, m_tdest, m_tlast}, exp);
            end
            out_cnt++;
         end
      end
   end

`ifdef AXIS_SUBSET_PKT_CNT_EN
   always @(posedge clk) begin
      if (!stall_done) begin
         #1;
         if (!stall_done) m_tready = ($urandom_range(0, 3) != 0);
      end
   end
`endif

   initial begin
`ifdef AXIS_SUBSET_PKT_CNT_EN
      stall_done = 1'b1;
`endif
      // Reset state
      areset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_tvalid", m_tvalid, 1'b0);
      check("rst_s_tready", s_tready, 1'b0);
      check("rst_pkt_active", pkt_active, 1'b0);
      check("rst_dest_err", dest_err, 1'b0);
      check("rst_state", dbg_state, PKT_IDLE);
      areset = 1'b0;
      #1;
      check("s_tready_at_release", s_tready, 1'b0);
      @(posedge clk);
      #1;
      check("s_tready_after_edge", s_tready, 1'b1);

      // 1: 8 back-to-back beats, one packet with tdest 2
      m_tready = 1'b1;
      c0 = cyc;
      o0 = out_cnt;
      for (int i = 0; i < 8; i++) begin
         send(64'h100 + 64'(i), 2'd2, (i == 7), 2'd2);
         if (i == 0) check("latency_m_tvalid", m_tvalid, 1'b1);
      end
      check("b2b_accept_cycles", cyc - c0, 8);
      @(posedge clk);
      #1;
      check("b2b_out_count", out_cnt - o0, 8);
      check("b2b_idle_after", m_tvalid, 1'b0);

      // 2: 5-cycle output stall in the middle of a stream
      a0 = acc_cnt;
      o0 = out_cnt;
      fork
         begin
            for (int i = 0; i < 6; i++) send(64'h200 + 64'(i), 2'd1, (i == 5), 2'd1);
         end
         begin
            stall_n = 0;
            while ((acc_cnt - a0) < 2 && stall_n < TMO) begin
               @(posedge clk);
               #2;
               stall_n++;
            end
            m_tready = 1'b0;
            repeat (5) begin
               @(posedge clk);
               #2;
            end
            check("stall_buffered", (acc_cnt - a0) - (out_cnt - o0), 2);
            check("stall_s_tready", s_tready, 1'b0);
            check("stall_m_tvalid", m_tvalid, 1'b1);
            m_tready = 1'b1;
         end
      join
      wait_drain();
      check("stall_total_out", out_cnt - o0, 6);

      // 3: locked tdest; beats 2..4 all differ from the first beat's dest
      e0 = err_cnt;
      send(64'h300, 2'd2, 1'b0, 2'd2);
      check("lock_active_1", pkt_active, 1'b1);
      check("lock_state_1", dbg_state, PKT_IN);
      send(64'h301, 2'd1, 1'b0, 2'd2);
      check("lock_active_2", pkt_active, 1'b1);
      send(64'h302, 2'd1, 1'b0, 2'd2);
      check("lock_active_3", pkt_active, 1'b1);
      send(64'h303, 2'd3, 1'b1, 2'd2);
      check("lock_active_end", pkt_active, 1'b0);
      wait_drain();
      check("lock_dest_err_count", err_cnt - e0, 3);

      // 4: single-beat packet, then a clean 2-beat packet
      e0 = err_cnt;
      send(64'h400, 2'd3, 1'b1, 2'd3);
      check("single_active", pkt_active, 1'b0);
      send(64'h401, 2'd1, 1'b0, 2'd1);
      check("two_beat_active", pkt_active, 1'b1);
      send(64'h402, 2'd1, 1'b1, 2'd1);
      wait_drain();
      check("two_beat_no_err", err_cnt - e0, 0);

      // 5: reset with both entries full in mid-packet
      m_tready = 1'b0;
      send(64'h500, 2'd0, 1'b0, 2'd0);
      send(64'h501, 2'd2, 1'b0, 2'd0);
      check("full_s_tready", s_tready, 1'b0);
      areset = 1'b1;
      #1;
      check("midrst_m_tvalid", m_tvalid, 1'b0);
      check("midrst_pkt_active", pkt_active, 1'b0);
      check("midrst_s_tready", s_tready, 1'b0);
      exp_q.delete();
      @(posedge clk);
      #1;
      areset = 1'b0;
      m_tready = 1'b1;
      send(64'h510, 2'd1, 1'b0, 2'd1);
      send(64'h511, 2'd1, 1'b0, 2'd1);
      send(64'h512, 2'd1, 1'b1, 2'd1);
      wait_drain();
      check("postrst_idle", pkt_active, 1'b0);

`ifdef AXIS_SUBSET_PKT_CNT_EN
      // 6: packet counter with random output stalls, then wrap
      areset = 1'b1;
      #1;
      check("cnt_reset", pkt_count, 32'd0);
      @(posedge clk);
      #1;
      areset = 1'b0;
      stall_done = 1'b0;
      send(64'h600, 2'd0, 1'b1, 2'd0);
      for (int i = 0; i < 4; i++) send(64'h610 + 64'(i), 2'd2, (i == 3), 2'd2);
      for (int i = 0; i < 2; i++) send(64'h620 + 64'(i), 2'd3, (i == 1), 2'd3);
      stall_done = 1'b1;
      m_tready = 1'b1;
      wait_drain();
      @(posedge clk);
      #1;
      check("cnt_three", pkt_count, 32'd3);
      force dut.pkt_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.pkt_cnt_q;
      #1;
      check("cnt_preset", pkt_count, 32'hFFFF_FFFF);
      send(64'h630, 2'd1, 1'b1, 2'd1);
      wait_drain();
      @(posedge clk);
      #1;
      check("cnt_wrap", pkt_count, 32'd0);
`endif

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
